// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-ported VRAM between GPU pixel fetch and
// buffered CPU writes, scheduled by the video timing counters.
//
// Ports:
//   clk, rst_n            pixel clock, async active-low reset
//   hcounter, vcounter    video timing position
//   gpu_req/addr/gnt      fetch request, address, combinational grant
//   gpu_rvalid/rdata      read return, two cycles after grant
//   cpu_wr_valid/addr/data/ready  CPU write offer into the FIFO
//   vram_addr/wdata/we    registered VRAM command
//   vram_rdata            VRAM synchronous read data
//   fifo_level            CPU write FIFO occupancy
//   cpu_stall_cnt         saturating count of refused CPU write cycles
module vram_arbiter #(
    parameter int AW       = 15,
    parameter int DW       = 8,
    parameter int DEPTH    = 4,
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 400,
    parameter int PREFETCH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [9:0]               hcounter,
    input  logic [9:0]               vcounter,
    input  logic                     gpu_req,
    input  logic [AW-1:0]            gpu_addr,
    output logic                     gpu_gnt,
    output logic                     gpu_rvalid,
    output logic [DW-1:0]            gpu_rdata,
    input  logic                     cpu_wr_valid,
    input  logic [AW-1:0]            cpu_wr_addr,
    input  logic [DW-1:0]            cpu_wr_data,
    output logic                     cpu_wr_ready,
    output logic [AW-1:0]            vram_addr,
    output logic [DW-1:0]            vram_wdata,
    output logic                     vram_we,
    input  logic [DW-1:0]            vram_rdata,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              cpu_stall_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [9:0]    H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]    H_OPEN = 10'(H_TOTAL - PREFETCH);
    localparam bit            PF_EN  = (PREFETCH != 0);
    localparam logic [LW-1:0] FULL   = LW'(DEPTH);
    localparam logic [LW-1:0] L_ONE  = LW'(1);
    localparam logic [PW-1:0] P_ONE  = PW'(1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_FETCH = 1'b1
    } phase_t;

    phase_t phase;

    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    logic win;
    logic fifo_empty;
    logic push;
    logic pop;
    logic rd_pend;

    // Phase is not needed by the arbitration path; it is kept visible for debug.
    logic phase_unused;
    assign phase_unused = (phase == ST_FETCH);

    // Fetch window: active lines, active pixels plus the prefetch run-in
    // at the end of the previous line.
    assign win = (vcounter < V_ACT) &&
                 ((hcounter < H_ACT) || (PF_EN && (hcounter >= H_OPEN)));

    always_comb begin
        fifo_empty   = (fifo_level == '0);
        cpu_wr_ready = (fifo_level != FULL);
        push         = cpu_wr_valid && cpu_wr_ready;
        gpu_gnt      = 1'b0;
        pop          = 1'b0;
        if (win) begin
            // GPU owns the port; CPU drains only in idle fetch cycles.
            gpu_gnt = gpu_req;
            pop     = !fifo_empty && !gpu_req;
        end else begin
            // Blanking: pending CPU writes take precedence.
            gpu_gnt = gpu_req && fifo_empty;
            pop     = !fifo_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wptr] <= cpu_wr_addr;
            q_data[wptr] <= cpu_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase         <= ST_BLANK;
            wptr          <= '0;
            rptr          <= '0;
            fifo_level    <= '0;
            vram_addr     <= '0;
            vram_wdata    <= '0;
            vram_we       <= 1'b0;
            rd_pend       <= 1'b0;
            gpu_rvalid    <= 1'b0;
            gpu_rdata     <= '0;
            cpu_stall_cnt <= '0;
        end else begin
            phase <= win ? ST_FETCH : ST_BLANK;

            if (push) wptr <= wptr + P_ONE;
            if (pop)  rptr <= rptr + P_ONE;

            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + L_ONE;
                2'b01:   fifo_level <= fifo_level - L_ONE;
                default: fifo_level <= fifo_level;
            endcase

            // pop and gpu_gnt are mutually exclusive by construction.
            vram_we <= pop;
            if (pop) begin
                vram_addr  <= q_addr[rptr];
                vram_wdata <= q_data[rptr];
            end else if (gpu_gnt) begin
                vram_addr  <= gpu_addr;
            end

            rd_pend    <= gpu_gnt;
            gpu_rvalid <= rd_pend;
            gpu_rdata  <= vram_rdata;

            if (cpu_wr_valid && !cpu_wr_ready &&
                (cpu_stall_cnt != 16'hFFFF)) begin
                cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of window arbitration, read/write
// latency, FIFO full handling, reset and a PREFETCH=0 build.
module tb_vram_arbiter;

    localparam int AW    = 15;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [9:0]    hcounter = '0;
    logic [9:0]    vcounter = '0;
    logic          gpu_req = 1'b0;
    logic [AW-1:0] gpu_addr = '0;
    logic          cpu_wr_valid = 1'b0;
    logic [AW-1:0] cpu_wr_addr = '0;
    logic [DW-1:0] cpu_wr_data = '0;

    logic          gpu_gnt, gpu_rvalid, cpu_wr_ready, vram_we;
    logic [DW-1:0] gpu_rdata, vram_wdata, vram_rdata;
    logic [AW-1:0] vram_addr;
    logic [LW-1:0] fifo_level;
    logic [15:0]   cpu_stall_cnt;

    logic          p0_gnt, p0_rvalid, p0_ready, p0_we;
    logic [DW-1:0] p0_rdata, p0_wdata, p0_vram_rdata;
    logic [AW-1:0] p0_addr;
    logic [LW-1:0] p0_level;
    logic [15:0]   p0_stall;

    always #5 clk = ~clk;

    // VRAM stand-in: each address holds a fixed pattern of itself.
    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    assign vram_rdata    = rd(vram_addr);
    assign p0_vram_rdata = rd(p0_addr);

    vram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .hcounter(hcounter), .vcounter(vcounter),
        .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_gnt(gpu_gnt),
        .gpu_rvalid(gpu_rvalid), .gpu_rdata(gpu_rdata),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_addr(cpu_wr_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_wr_ready(cpu_wr_ready),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
        .vram_rdata(vram_rdata), .fifo_level(fifo_level),
        .cpu_stall_cnt(cpu_stall_cnt)
    );

    vram_arbiter #(.PREFETCH(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .hcounter(hcounter), .vcounter(vcounter),
        .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_gnt(p0_gnt),
        .gpu_rvalid(p0_rvalid), .gpu_rdata(p0_rdata),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_addr(cpu_wr_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_wr_ready(p0_ready),
        .vram_addr(p0_addr), .vram_wdata(p0_wdata), .vram_we(p0_we),
        .vram_rdata(p0_vram_rdata), .fifo_level(p0_level),
        .cpu_stall_cnt(p0_stall)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge, return at the
    // following falling edge where outputs are sampled.
    task automatic cyc(input logic [9:0] h, input logic [9:0] v,
                       input logic req, input logic [AW-1:0] ga,
                       input logic wv, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd);
        @(posedge clk);
        #1;
        hcounter     = h;
        vcounter     = v;
        gpu_req      = req;
        gpu_addr     = ga;
        cpu_wr_valid = wv;
        cpu_wr_addr  = wa;
        cpu_wr_data  = wd;
        @(negedge clk);
    endtask

    typedef struct {
        logic [9:0]    h;
        logic [9:0]    v;
        logic          req;
        logic          gnt;
        logic [LW-1:0] lvl;
        logic          we;
        logic [AW-1:0] wa;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{10'd100, 10'd10,   1'b1, 1'b1, 3'd4, 1'b0, 15'h0};
        tbl[1]  = '{10'd319, 10'd10,   1'b1, 1'b1, 3'd4, 1'b0, 15'h0};
        tbl[2]  = '{10'd320, 10'd10,   1'b1, 1'b0, 3'd4, 1'b0, 15'h0};
        tbl[3]  = '{10'd391, 10'd10,   1'b1, 1'b0, 3'd3, 1'b1, 15'h100};
        tbl[4]  = '{10'd392, 10'd10,   1'b1, 1'b1, 3'd2, 1'b1, 15'h101};
        tbl[5]  = '{10'd399, 10'd10,   1'b1, 1'b1, 3'd2, 1'b0, 15'h0};
        tbl[6]  = '{10'd0,   10'd479,  1'b1, 1'b1, 3'd2, 1'b0, 15'h0};
        tbl[7]  = '{10'd0,   10'd480,  1'b1, 1'b0, 3'd2, 1'b0, 15'h0};
        tbl[8]  = '{10'd100, 10'd10,   1'b0, 1'b0, 3'd1, 1'b1, 15'h102};
        tbl[9]  = '{10'd100, 10'd10,   1'b1, 1'b1, 3'd0, 1'b1, 15'h103};
        tbl[10] = '{10'd320, 10'd500,  1'b1, 1'b1, 3'd0, 1'b0, 15'h0};
        tbl[11] = '{10'd0,   10'd1023, 1'b0, 1'b0, 3'd0, 1'b0, 15'h0};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_level", fifo_level, 0);
        chk("rst_we", vram_we, 0);
        chk("rst_addr", vram_addr, 0);
        chk("rst_wdata", vram_wdata, 0);
        chk("rst_rvalid", gpu_rvalid, 0);
        chk("rst_rdata", gpu_rdata, 0);
        chk("rst_stall", cpu_stall_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", cpu_wr_ready, 1);

        // Table: prefill four writes under GPU priority, then walk windows
        for (int k = 0; k < 4; k++)
            cyc(10'(k), 10'd10, 1'b1, '0, 1'b1, 15'(32'h100 + k), 8'(8'h10 + k));
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].h, tbl[i].v, tbl[i].req, 15'(32'h3000 + i), 1'b0, '0, '0);
            chk($sformatf("tbl%0d_gnt", i), gpu_gnt, tbl[i].gnt);
            chk($sformatf("tbl%0d_lvl", i), fifo_level, tbl[i].lvl);
            chk($sformatf("tbl%0d_we", i), vram_we, tbl[i].we);
            if (tbl[i].we)
                chk($sformatf("tbl%0d_waddr", i), vram_addr, tbl[i].wa);
        end
        repeat (2) cyc(10'd0, 10'd500, 1'b0, '0, 1'b0, '0, '0);

        // Streaming reads across the prefetch run-in and active line
        for (int j = 0; j < 328; j++) begin
            cyc((j < 8) ? 10'(392 + j) : 10'(j - 8), 10'd10, 1'b1,
                15'(32'h1000 + j), 1'b0, '0, '0);
            chk("str_gnt", gpu_gnt, 1);
            chk("str_we", vram_we, 0);
            if (j >= 1) chk("str_addr", vram_addr, 32'h1000 + j - 1);
            chk("str_rvalid", gpu_rvalid, (j >= 2));
            if (j >= 2) chk("str_rdata", gpu_rdata, rd(15'(32'h1000 + j - 2)));
        end
        for (int t = 0; t < 3; t++) begin
            cyc(10'd320, 10'd500, 1'b0, '0, 1'b0, '0, '0);
            chk("tail_rvalid", gpu_rvalid, (t < 2));
            if (t < 2) chk("tail_rdata", gpu_rdata, rd(15'(32'h1000 + 326 + t)));
        end

        // Starved CPU: GPU holds the port for the whole active line
        for (int h = 0; h < 326; h++) begin
            int k;
            k = (h < 4) ? h : 4;
            cyc(10'(h), 10'd10, 1'b1, 15'h0, (h < 320),
                15'(32'h2000 + k), 8'(8'hA0 + k));
            if (h == 3) begin
                chk("stv_lvl3", fifo_level, 3);
                chk("stv_rdy3", cpu_wr_ready, 1);
            end
            if (h == 4) begin
                chk("stv_lvl4", fifo_level, 4);
                chk("stv_rdy4", cpu_wr_ready, 0);
            end
            if (h == 5) chk("stv_stall5", cpu_stall_cnt, 1);
            if (h == 320) begin
                chk("stv_stall", cpu_stall_cnt, 316);
                chk("stv_gnt320", gpu_gnt, 0);
                chk("stv_we320", vram_we, 0);
                chk("stv_lvl320", fifo_level, 4);
            end
            if (h >= 321 && h <= 324) begin
                chk("stv_we", vram_we, 1);
                chk("stv_waddr", vram_addr, 32'h2000 + h - 321);
                chk("stv_wdata", vram_wdata, 32'hA0 + h - 321);
            end
            if (h == 324) chk("stv_gnt324", gpu_gnt, 1);
            if (h == 325) begin
                chk("stv_we325", vram_we, 0);
                chk("stv_lvl325", fifo_level, 0);
            end
        end

        // Blank priority: two queued writes beat a GPU request
        cyc(10'd0, 10'd10, 1'b1, '0, 1'b1, 15'h3000, 8'hC0);
        cyc(10'd1, 10'd10, 1'b1, '0, 1'b1, 15'h3001, 8'hC1);
        cyc(10'd0, 10'd500, 1'b1, 15'h0777, 1'b0, '0, '0);
        chk("blk0_gnt", gpu_gnt, 0);
        chk("blk0_lvl", fifo_level, 2);
        cyc(10'd0, 10'd500, 1'b1, 15'h0777, 1'b0, '0, '0);
        chk("blk1_gnt", gpu_gnt, 0);
        chk("blk1_we", vram_we, 1);
        chk("blk1_addr", vram_addr, 32'h3000);
        chk("blk1_data", vram_wdata, 32'hC0);
        cyc(10'd0, 10'd500, 1'b1, 15'h0777, 1'b0, '0, '0);
        chk("blk2_gnt", gpu_gnt, 1);
        chk("blk2_we", vram_we, 1);
        chk("blk2_addr", vram_addr, 32'h3001);
        chk("blk2_data", vram_wdata, 32'hC1);
        cyc(10'd0, 10'd500, 1'b0, '0, 1'b0, '0, '0);
        chk("blk3_we", vram_we, 0);
        chk("blk3_addr", vram_addr, 32'h0777);
        cyc(10'd0, 10'd500, 1'b0, '0, 1'b0, '0, '0);
        chk("blk4_rvalid", gpu_rvalid, 1);
        chk("blk4_rdata", gpu_rdata, rd(15'h0777));

        // FIFO full: pop and offer in the same cycle
        for (int k = 0; k < 4; k++)
            cyc(10'(k), 10'd10, 1'b1, '0, 1'b1, 15'(32'h4000 + k), 8'(8'hD0 + k));
        cyc(10'd0, 10'd500, 1'b1, '0, 1'b1, 15'h4004, 8'hD4);
        chk("full_rdy", cpu_wr_ready, 0);
        chk("full_lvl", fifo_level, 4);
        chk("full_gnt", gpu_gnt, 0);
        cyc(10'd0, 10'd500, 1'b1, '0, 1'b1, 15'h4004, 8'hD4);
        chk("full1_rdy", cpu_wr_ready, 1);
        chk("full1_lvl", fifo_level, 3);
        chk("full1_stall", cpu_stall_cnt, 317);
        chk("full1_addr", vram_addr, 32'h4000);
        for (int m = 1; m < 5; m++) begin
            cyc(10'd0, 10'd500, 1'b1, '0, 1'b0, '0, '0);
            chk("drain_we", vram_we, 1);
            chk("drain_addr", vram_addr, 32'h4000 + m);
            chk("drain_data", vram_wdata, 32'hD0 + m);
            chk("drain_lvl", fifo_level, (m == 1) ? 3 : 4 - m);
        end
        cyc(10'd0, 10'd500, 1'b1, '0, 1'b0, '0, '0);
        chk("drain_end_we", vram_we, 0);
        chk("drain_end_gnt", gpu_gnt, 1);

        // Reset mid-operation: three queued writes, reads in flight
        cyc(10'd0, 10'd10, 1'b1, 15'h10, 1'b1, 15'h5000, 8'hE0);
        cyc(10'd1, 10'd10, 1'b1, 15'h11, 1'b1, 15'h5001, 8'hE1);
        cyc(10'd2, 10'd10, 1'b1, 15'h12, 1'b1, 15'h5002, 8'hE2);
        @(posedge clk);
        #1;
        hcounter = 10'd3;
        cpu_wr_valid = 1'b0;
        #1 chk("mid_lvl", fifo_level, 3);
        #1 rst_n = 1'b0;
        gpu_req = 1'b0;
        #1;
        chk("mid_rst_lvl", fifo_level, 0);
        chk("mid_rst_we", vram_we, 0);
        chk("mid_rst_addr", vram_addr, 0);
        chk("mid_rst_wdata", vram_wdata, 0);
        chk("mid_rst_rvalid", gpu_rvalid, 0);
        chk("mid_rst_rdata", gpu_rdata, 0);
        chk("mid_rst_stall", cpu_stall_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            cyc(10'd10, 10'd10, 1'b0, '0, 1'b0, '0, '0);
            chk("post_rvalid", gpu_rvalid, 0);
            chk("post_lvl", fifo_level, 0);
            chk("post_rdy", cpu_wr_ready, 1);
        end

        // PREFETCH=0 build versus default build at the line wrap
        cyc(10'd0, 10'd0, 1'b1, '0, 1'b1, 15'h6000, 8'hF0);
        cyc(10'd1, 10'd0, 1'b1, '0, 1'b1, 15'h6001, 8'hF1);
        cyc(10'd399, 10'd0, 1'b1, '0, 1'b0, '0, '0);
        chk("pf0_gnt399", p0_gnt, 0);
        chk("pf0_lvl399", p0_level, 2);
        chk("pf8_gnt399", gpu_gnt, 1);
        cyc(10'd0, 10'd0, 1'b1, '0, 1'b0, '0, '0);
        chk("pf0_gnt0", p0_gnt, 1);
        chk("pf0_lvl0", p0_level, 1);
        chk("pf0_we0", p0_we, 1);
        chk("pf0_addr0", p0_addr, 32'h6000);
        chk("pf8_gnt0", gpu_gnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
